// File: rtl/i2c_bit_ctrl.sv
// I2C master bit engine: runs one START/STOP/WRITE/READ as four timed phases,
// driving open-drain enables and watching the filtered lines for stretch/arbitration.
module i2c_bit_ctrl #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_an,
  input  logic [PRE_W-1:0] prescale,
  input  logic [2:0]       cmd,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic             txBit,
  input  logic             sclIn,
  input  logic             sdaIn,
  output logic             sclOe,
  output logic             sdaOe,
  output logic             rxBit,
  output logic             done,
  output logic             arbLost,
  output logic             busy
);

  localparam logic [2:0] IDLE = 3'd0, PH_A = 3'd1, PH_B = 3'd2, PH_C = 3'd3, PH_D = 3'd4;
  localparam logic [2:0] C_START = 3'd1, C_STOP = 3'd2, C_WRITE = 3'd3, C_READ = 3'd4;

  logic [2:0]       state;
  logic [2:0]       cmd_q;
  logic             tx_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] cnt;

  logic accept, in_bc, stall, arb_loss;

  // {scl_pull, sda_pull} for a command in a given phase
  function automatic logic [1:0] line_lv(input logic [2:0] c, input logic tx,
                                         input logic [2:0] ph);
    logic lv_scl, lv_sda;
    lv_scl = (ph == PH_A) || (ph == PH_D && c != C_STOP);
    case (c)
      C_START: lv_sda = (ph == PH_C) || (ph == PH_D);
      C_STOP:  lv_sda = (ph == PH_A) || (ph == PH_B);
      C_WRITE: lv_sda = ~tx;
      default: lv_sda = 1'b0;
    endcase
    return {lv_scl, lv_sda};
  endfunction

  assign cmdReady = (state == IDLE);
  assign accept   = cmdValid && cmdReady && (cmd inside {[C_START:C_READ]});
  assign in_bc    = (state == PH_B) || (state == PH_C);
  // A low SCL while we release it is either a stretching slave or filter latency
  assign stall    = in_bc && !sclIn;
  assign arb_loss = in_bc && !sdaIn &&
                    ((cmd_q == C_WRITE && tx_q) || (cmd_q == C_STOP && state == PH_C));

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state   <= IDLE;
      cmd_q   <= 3'd0;
      tx_q    <= 1'b0;
      pre_q   <= '0;
      cnt     <= '0;
      sclOe   <= 1'b0;
      sdaOe   <= 1'b0;
      rxBit   <= 1'b0;
      done    <= 1'b0;
      arbLost <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done    <= 1'b0;
      arbLost <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          cmd_q            <= cmd;
          tx_q             <= txBit;
          pre_q            <= prescale;
          cnt              <= prescale;
          state            <= PH_A;
          {sclOe, sdaOe}   <= line_lv(cmd, txBit, PH_A);
        end
      end else if (arb_loss) begin
        state   <= IDLE;
        cnt     <= '0;
        sclOe   <= 1'b0;
        sdaOe   <= 1'b0;
        done    <= 1'b1;
        arbLost <= 1'b1;
        busy    <= 1'b0;
      end else if (!stall) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (state == PH_D) begin
          // Lines keep their PH_D levels while idle
          state <= IDLE;
          done  <= 1'b1;
          if (cmd_q == C_START) busy <= 1'b1;
          if (cmd_q == C_STOP)  busy <= 1'b0;
        end else begin
          if (state == PH_C && cmd_q == C_READ) rxBit <= sdaIn;
          state          <= state + 1'b1;
          cnt            <= pre_q;
          {sclOe, sdaOe} <= line_lv(cmd_q, tx_q, state + 1'b1);
        end
      end
    end
  end

endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
- Bit-level I2C master line driver: the transmit-side counterpart to the block that filters and edge-detects SCL/SDA.
- Executes one command at a time: START, STOP, WRITE bit or READ bit.
- Drives the open-drain pull-down enables for SCL and SDA, and reads the filtered line levels back for clock stretching, arbitration and read sampling.
- Sits between the byte controller (above) and the pad open-drain cells plus line filters (below).

Parameters:
PRE_W, 8, width of the prescale input (phase length counter width)

Ports:
clk  input  1  system clock
rst_an  input  1  system reset, asynchronous, active low
prescale  input  PRE_W  phase length minus 1, in clk cycles; sampled when a command is accepted
cmd  input  3  0=NOP, 1=START, 2=STOP, 3=WRITE, 4=READ; 5-7 are treated as NOP
cmdValid  input  1  command request
cmdReady  output  1  high when idle and able to accept a command
txBit  input  1  bit to send for WRITE; sampled at accept
sclIn  input  1  filtered, registered SCL level
sdaIn  input  1  filtered, registered SDA level
sclOe  output  1  1 = pull SCL low; 0 = release
sdaOe  output  1  1 = pull SDA low; 0 = release
rxBit  output  1  sampled SDA for READ; valid while done=1
done  output  1  one-cycle pulse when a command completes or is aborted
arbLost  output  1  one-cycle pulse, coincident with done, on arbitration loss
busy  output  1  high from START completion until STOP completion or arbitration loss

Behaviour:
- Reset (rst_an low, asynchronous): sclOe=0, sdaOe=0, done=0, arbLost=0, rxBit=0, busy=0, state=IDLE, phase counter=0. cmdReady goes 1 after reset.
- Reset mid-command aborts immediately: both lines released, no done pulse.
- States: IDLE, PH_A, PH_B, PH_C, PH_D.
- Accept: cmdValid & cmdReady & cmd in 1..4. On accept, latch cmd, txBit and prescale; next state is PH_A; cmdReady drops the following cycle.
- NOP or illegal codes are ignored: cmdReady stays 1.
- Phase length: each phase lasts prescale+1 clk cycles. Counter loads prescale on entry and decrements; the phase ends when it reaches 0. A bit with no stretching therefore lasts 4*(prescale+1) cycles.
- Clock stretching: in PH_B and PH_C the counter holds while sclIn=0. This also absorbs the filter latency after SCL is released.
- Line levels per phase (L = driven low, R = released), listed as A / B / C / D:
  - START: SCL L,R,R,L; SDA R,R,L,L
  - STOP: SCL L,R,R,R; SDA L,L,R,R
  - WRITE: SCL L,R,R,L; SDA = ~txBit (driven) in all four phases
  - READ: SCL L,R,R,L; SDA R in all four phases
- sclOe/sdaOe are registered and change on the first cycle of each phase.
- Completion: at the end of PH_D, assert done for 1 cycle and return to IDLE; cmdReady=1 in the same cycle.
- Idle line levels after completion: after STOP, both lines stay released. After START, WRITE or READ, SCL stays driven low and SDA keeps its PH_D level.
- READ sampling: rxBit is captured from sdaIn on the last cycle of PH_C and held until the next READ completes.
- busy: set on START done. Cleared on STOP done, on arbLost, and by reset.
- Arbitration loss is checked on every cycle of PH_B and PH_C:
  - WRITE with txBit=1: loss if sdaIn=0.
  - STOP: loss if sdaIn=0 during PH_C.
  - On loss: next cycle sclOe=0, sdaOe=0, done=1, arbLost=1, state=IDLE.
- A cmdValid held during an active command is ignored until cmdReady=1.

Test Plan:
1. Reset, then START with prescale=3 -> cmdReady low 16 cycles; sdaOe rises 8 cycles after PH_A start, sclOe rises at PH_D; done one cycle after cycle 16; busy=1.
2. WRITE txBit=0 then WRITE txBit=1, prescale=3, line model follows Oe -> sdaOe=1 / 0 held across all 16 cycles of each bit; SCL released only in PH_B/C; two done pulses; no arbLost.
3. READ with the model driving sdaIn=0 during PH_C, prescale=1 -> rxBit=0 with done after 8 cycles; repeat with sdaIn=1 -> rxBit=1.
4. WRITE with the model holding sclIn=0 for 20 extra cycles in PH_B, prescale=3 -> bit lasts 36 cycles; SCL level unchanged during the hold; done once.
5. WRITE txBit=1 with sdaIn forced 0 in PH_B -> next cycle arbLost=1, done=1, sclOe=0, sdaOe=0; busy=0.
6. STOP then assert rst_an low mid-PH_B of a WRITE -> after STOP both Oe=0, busy=0. On the mid-bit reset, outputs are 0 asynchronously, no done pulse, and cmdReady=1 after reset release.
